pipeline_hazard_ctrl: RTL
=========================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter REG_ADDR_WIDTH, default 5: register-file address width.
REQ-002 Parameter SFU_LATENCY, default 4: EX-stage occupancy in cycles of an SFU op; legal range 1..15.
REQ-003 Parameter CNT_WIDTH, default 16: stall performance-counter width.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-006 id_valid  in  1  decode stage holds a valid instruction.
REQ-007 id_rs1, id_rs2  in  REG_ADDR_WIDTH each  source register addresses.
REQ-008 id_rs1_en, id_rs2_en  in  1 each  source actually read.
REQ-009 id_rd  in  REG_ADDR_WIDTH  destination register address.
REQ-010 id_wr_en  in  1  instruction writes id_rd.
REQ-011 id_sfu  in  1  instruction is a multi-cycle SFU op.
REQ-012 stall  out  1  hold PC and the IF/ID stage register.
REQ-013 issue  out  1  decode instruction advances into EX this cycle.
REQ-014 ex_hold  out  1  hold the ID/EX stage register (SFU computing).
REQ-015 id_ex_bubble  out  1  load NOP into the ID/EX stage register.
REQ-016 wb_bubble  out  1  load NOP into the EX/WB stage register.
REQ-017 wb_wr_en  out  1  gated register-file write enable for the WB slot.
REQ-018 stall_count  out  CNT_WIDTH  saturating count of stalled valid-decode cycles.

Function
REQ-019 Block SHALL track two in-flight slots: E (instruction in EX) and W (instruction in WB), each holding valid, wr_en, rd.
REQ-020 match(r) SHALL be (E.valid & E.wr_en & E.rd==r) | (W.valid & W.wr_en & W.rd==r); address 0 is not exempt.
REQ-021 hazard SHALL be id_valid & ((id_rs1_en & match(id_rs1)) | (id_rs2_en & match(id_rs2))); no forwarding exists.
REQ-022 A 4-bit down-counter sfu_cnt SHALL exist; ex_hold = (sfu_cnt != 0).
REQ-023 stall SHALL be id_valid & (hazard | ex_hold); issue = id_valid & ~stall.
REQ-024 id_ex_bubble SHALL be ~ex_hold & ~issue; wb_bubble = ex_hold; wb_wr_en = W.valid & W.wr_en.
REQ-025 All outputs are combinational from state and current inputs; zero-cycle decision latency.
REQ-026 When ex_hold: E unchanged, W <= invalid, sfu_cnt <= sfu_cnt-1.
REQ-027 When ~ex_hold: W <= E; E <= issue ? {1, id_wr_en, id_rd} : invalid.
REQ-028 When ~ex_hold & issue & id_sfu: sfu_cnt <= SFU_LATENCY-1 (SFU_LATENCY=1 behaves as a normal op).
REQ-029 An SFU op SHALL occupy E for exactly SFU_LATENCY cycles, then move to W for one cycle.
REQ-030 stall_count SHALL increment when stall=1, saturating at all-ones; never wraps.
REQ-031 Simultaneous E and W match on the same source: stall (either match suffices); rs1 and rs2 equal: single compare result, no double effect.
REQ-032 id_valid=0: stall=0, issue=0, no counter increment, bubble inserted into E as per REQ-027.
REQ-033 Decode instruction writing a register it also reads SHALL compare only against E/W, not itself.

Reset
REQ-034 reset=1 SHALL asynchronously clear E, W, sfu_cnt, stall_count to 0.
REQ-035 With reset state and id_valid=0: stall=0, issue=0, ex_hold=0, id_ex_bubble=1, wb_bubble=0, wb_wr_en=0, stall_count=0.
REQ-036 reset asserted mid-SFU op SHALL abort it; first cycle after release ex_hold=0 and no pending write exists.

Verification
REQ-037 RAW via E: issue wr r3 at cycle 0; cycle 1 decode reads rs1=r3 -> stall=1 cycles 1-2, issue=1 cycle 3, stall_count=2.
REQ-038 Independent stream: 10 back-to-back ops, disjoint registers -> issue=1 every cycle, stall_count stays 0, wb_wr_en follows issue by 2 cycles.
REQ-039 SFU, SFU_LATENCY=4: SFU op issued cycle 0, next decode independent -> ex_hold=1 cycles 1-3, wb_bubble=1 cycles 1-3, dependent-free op issues cycle 4.
REQ-040 Saturation: CNT_WIDTH=4, force 20 stalled cycles -> stall_count reaches 15 and holds.
REQ-041 Reset at cycle 2 of SFU op -> all outputs at reset values immediately; after release a valid independent op issues on first cycle.
REQ-042 id_rs1_en=0 with id_rs1 matching E.rd -> no stall, issue=1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: RAW and multi-cycle SFU stall control for a decode stage feeding
// a two-slot EX/WB pipeline that has no forwarding paths.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int SFU_LATENCY    = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_rs1_en,
  input  logic                      id_rs2_en,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_wr_en,
  input  logic                      id_sfu,
  output logic                      stall,
  output logic                      issue,
  output logic                      ex_hold,
  output logic                      id_ex_bubble,
  output logic                      wb_bubble,
  output logic                      wb_wr_en,
  output logic [CNT_WIDTH-1:0]      stall_count
);
  localparam logic [3:0] SFU_RELOAD = 4'(SFU_LATENCY - 1);
  logic                      e_valid_q, e_valid_d, e_wr_q, e_wr_d;
  logic                      w_valid_q, w_valid_d, w_wr_q, w_wr_d;
  logic [REG_ADDR_WIDTH-1:0] e_rd_q, e_rd_d, w_rd_q, w_rd_d;
  logic [3:0]                sfu_cnt_q, sfu_cnt_d;
  logic [CNT_WIDTH-1:0]      stall_count_q, stall_count_d;
  logic                      e_live, w_live, rs1_hit, rs2_hit, hazard;
  assign e_live  = e_valid_q & e_wr_q;
  assign w_live  = w_valid_q & w_wr_q;
  // Only in-flight writers are compared; the decode instruction's own rd never matches itself
  assign rs1_hit = id_rs1_en & ((e_live & (e_rd_q == id_rs1)) | (w_live & (w_rd_q == id_rs1)));
  assign rs2_hit = id_rs2_en & ((e_live & (e_rd_q == id_rs2)) | (w_live & (w_rd_q == id_rs2)));
  assign hazard       = id_valid & (rs1_hit | rs2_hit);
  assign ex_hold      = sfu_cnt_q != 4'd0;
  assign stall        = id_valid & (hazard | ex_hold);
  assign issue        = id_valid & ~stall;
  assign id_ex_bubble = ~ex_hold & ~issue;
  assign wb_bubble    = ex_hold;
  assign wb_wr_en     = w_live;
  assign stall_count  = stall_count_q;
  always_comb begin
    e_valid_d     = ex_hold ? e_valid_q : issue;
    e_wr_d        = ex_hold ? e_wr_q : issue & id_wr_en;
    e_rd_d        = ex_hold ? e_rd_q : id_rd;
    w_valid_d     = ~ex_hold & e_valid_q;
    w_wr_d        = e_wr_q;
    w_rd_d        = e_rd_q;
    sfu_cnt_d     = ex_hold ? sfu_cnt_q - 4'd1 : (issue & id_sfu) ? SFU_RELOAD : 4'd0;
    stall_count_d = (stall && !(&stall_count_q)) ? stall_count_q + 1'b1 : stall_count_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid_q     <= 1'b0;
      e_wr_q        <= 1'b0;
      e_rd_q        <= '0;
      w_valid_q     <= 1'b0;
      w_wr_q        <= 1'b0;
      w_rd_q        <= '0;
      sfu_cnt_q     <= 4'd0;
      stall_count_q <= '0;
    end else begin
      e_valid_q     <= e_valid_d;
      e_wr_q        <= e_wr_d;
      e_rd_q        <= e_rd_d;
      w_valid_q     <= w_valid_d;
      w_wr_q        <= w_wr_d;
      w_rd_q        <= w_rd_d;
      sfu_cnt_q     <= sfu_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end
endmodule
